// File: rtl/adder_tree_sched.sv
// Round-robin scheduler feeding a pipelined 8-operand adder tree, with a credit-protected FWFT result FIFO.
// Optional per-requester grant and stall statistics are enabled with `define ADDER_TREE_SCHED_STATS_EN.
module adder_tree_sched #(
  parameter int ADDER_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 req_valid,
  input  logic [4*8*ADDER_WIDTH-1:0] req_data,
  output logic [3:0]                 req_ready,
  output logic                       res_valid,
  output logic [1:0]                 res_id,
  output logic [ADDER_WIDTH+2:0]     res_sum,
  input  logic                       res_ready
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [63:0]                grant_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int W  = ADDER_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]      last_grant_q, last_grant_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            rdy_en_q, rdy_en_d;
  logic            s1_valid_q, s1_valid_d;
  logic [1:0]      s1_id_q, s1_id_d;
  logic [8*W-1:0]  s1_ops_q, s1_ops_d;
  logic            s2_valid_q, s2_valid_d;
  logic [1:0]      s2_id_q, s2_id_d;
  logic [W+2:0]    s2_sum_q, s2_sum_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;

  logic [1:0]      id_mem  [FIFO_DEPTH];
  logic [W+2:0]    sum_mem [FIFO_DEPTH];

  logic            grant_any;
  logic [1:0]      grant_idx;
  logic            credit_ok;
  logic            accept;
  logic            pop;
  logic            fifo_empty;

  logic [W:0]      lvl1 [4];
  logic [W+1:0]    lvl2 [2];
  logic [W+2:0]    lvl3;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!grant_any && req_valid[last_grant_q + 2'(i + 1)]) begin
        grant_any = 1'b1;
        grant_idx = last_grant_q + 2'(i + 1);
      end
    end
  end

  // rdy_en_q keeps grants off for the first cycle after reset is released.
  assign credit_ok  = rdy_en_q && !rst && (inflight_q != DEPTH_C);
  assign accept     = credit_ok && grant_any;
  assign req_ready  = accept ? (4'b0001 << grant_idx) : 4'b0000;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign res_valid  = !rst && !fifo_empty;
  assign pop        = res_valid && res_ready;
  assign res_id     = res_valid ? id_mem[rd_ptr_q[AW-1:0]]  : '0;
  assign res_sum    = res_valid ? sum_mem[rd_ptr_q[AW-1:0]] : '0;

  // Each level widens by one bit, so no carry is ever lost.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lvl1[j] = {1'b0, s1_ops_q[2*j*W +: W]} + {1'b0, s1_ops_q[(2*j+1)*W +: W]};
    end
    for (int j = 0; j < 2; j++) begin
      lvl2[j] = {1'b0, lvl1[2*j]} + {1'b0, lvl1[2*j+1]};
    end
    lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

  always_comb begin
    last_grant_d = accept ? grant_idx : last_grant_q;
    rdy_en_d     = 1'b1;

    unique case ({accept, pop})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    s1_valid_d = accept;
    s1_id_d    = accept ? grant_idx : s1_id_q;
    s1_ops_d   = accept ? req_data[grant_idx*8*W +: 8*W] : s1_ops_q;

    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    s2_sum_d   = lvl3;

    wr_ptr_d   = wr_ptr_q + (AW+1)'(s2_valid_q);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      last_grant_q <= 2'd3;
      inflight_q   <= '0;
      rdy_en_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_ops_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= '0;
      s2_sum_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      rdy_en_q     <= rdy_en_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_ops_q     <= s1_ops_d;
      s2_valid_q   <= s2_valid_d;
      s2_id_q      <= s2_id_d;
      s2_sum_q     <= s2_sum_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Credit accounting guarantees a free slot for every stage-2 write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the cleared pointers mark every entry empty.
    if (s2_valid_q) begin
      id_mem[wr_ptr_q[AW-1:0]]  <= s2_id_q;
      sum_mem[wr_ptr_q[AW-1:0]] <= s2_sum_q;
    end
  end

`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [4];
  logic [15:0] grant_cnt_d [4];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      grant_cnt_d[r] = grant_cnt_q[r];
      if (accept && grant_idx == 2'(r) && grant_cnt_q[r] != 16'hFFFF) begin
        grant_cnt_d[r] = grant_cnt_q[r] + 16'd1;
      end
      grant_cnt[r*16 +: 16] = grant_cnt_q[r];
    end
    stall_cnt_d = stall_cnt_q;
    if (|req_valid && inflight_q == DEPTH_C && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) grant_cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < 4; r++) grant_cnt_q[r] <= grant_cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: latency, max operands, round-robin order, back-pressure, reset flush.
// Statistics checks compile in when ADDER_TREE_SCHED_STATS_EN is defined.
module tb_adder_tree_sched;
  localparam int W  = 4;
  localparam int OW = W + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [4*8*W-1:0] req_data;
  logic [3:0]       req_ready;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [OW-1:0]    res_sum;
  logic             res_ready;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [63:0]      grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int ops_mdl [4][8];
  int exp_q [$];

  adder_tree_sched #(.ADDER_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_ready (res_ready)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int r, input int k, input int v);
    ops_mdl[r][k] = v;
    req_data[(r*8+k)*W +: W] = W'(v);
  endtask

  function automatic int model_sum(input int r);
    int s = 0;
    for (int k = 0; k < 8; k++) s += ops_mdl[r][k];
    return s;
  endfunction

  // Holds reset for two edges with all requesters valid, then releases it.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b0;
    #1;
    check("rst_comb_valid", res_valid, 0);
    check("rst_comb_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_sum", res_sum, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("rel_ready", req_ready, 0);
    check("rel_valid", res_valid, 0);
    req_valid = 4'h0;
  endtask

  initial begin
    int got;
    int e;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) ops_mdl[r][k] = 0;

    do_reset();

    // Single request on requester 2, operands 1..8.
    for (int k = 0; k < 8; k++) set_op(2, k, k + 1);
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    check("single_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    check("single_lat1", res_valid, 0);
    @(negedge clk);
    check("single_lat2", res_valid, 0);
    @(negedge clk);
    check("single_valid", res_valid, 1);
    check("single_id", res_id, 2);
    check("single_sum", res_sum, 36);
    @(negedge clk);
    check("single_popped", res_valid, 0);

    // All-15 operands on requester 0, held while res_ready is low.
    for (int k = 0; k < 8; k++) set_op(0, k, 15);
    res_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    check("max_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("max_valid", res_valid, 1);
    check("max_id", res_id, 0);
    check("max_sum", res_sum, 120);
    @(negedge clk);
    check("max_hold_valid", res_valid, 1);
    check("max_hold_sum", res_sum, 120);
    check("max_hold_id", res_id, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("max_popped", res_valid, 0);

    // Round-robin with all four requesters continuously valid.
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) set_op(r, k, r + k);
    res_ready = 1'b1;
    exp_q.delete();
    got = 0;
    @(negedge clk);
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) req_valid = 4'h0;
      #1;
      if (c < 8) begin
        check($sformatf("rr_grant%0d", c), req_ready, 4'b0001 << (c % 4));
        exp_q.push_back(c % 4);
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("rr_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rr_id%0d", got), res_id, e);
          check($sformatf("rr_sum%0d", got), res_sum, model_sum(e));
          got++;
        end
      end
      @(negedge clk);
    end
    check("rr_count", got, 8);

    // Back-pressure on requester 1: four credits, then blocked.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), req_ready, (i < 4) ? 4'b0010 : 4'b0000);
      @(negedge clk);
    end
    check("bp_head_valid", res_valid, 1);
    check("bp_head_id", res_id, 1);
`ifdef ADDER_TREE_SCHED_STATS_EN
    check("bp_stall4", stall_cnt, 4);
`endif
    res_ready = 1'b1;
    #1;
    check("bp_pop_same_cycle", req_ready, 4'b0000);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("bp_credit", req_ready, 4'b0010);
    @(negedge clk);
    #1;
    check("bp_full_again", req_ready, 4'b0000);
`ifdef ADDER_TREE_SCHED_STATS_EN
    check("bp_stall5", stall_cnt, 5);
`endif

    // Reset with results buffered: nothing stale may emerge afterwards.
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("flush_buffered", res_valid, 1);
    do_reset();
    res_ready = 1'b1;
    @(negedge clk);
    check("flush_empty", res_valid, 0);
    req_valid = 4'hF;
    #1;
    check("flush_prio", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'h0;
    check("flush_lat1", res_valid, 0);
    @(negedge clk);
    check("flush_lat2", res_valid, 0);
    @(negedge clk);
    check("flush_valid", res_valid, 1);
    check("flush_id", res_id, 0);
    check("flush_sum", res_sum, 28);
    @(negedge clk);
    check("flush_done", res_valid, 0);

`ifdef ADDER_TREE_SCHED_STATS_EN
    // Saturation of requester 3's grant counter.
    do_reset();
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1000;
    repeat (70000) @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("sat_cnt3", grant_cnt[63:48], 16'hFFFF);
    check("sat_others", grant_cnt[47:0], 48'h0);
    check("sat_stall", stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  4  per-requester request valid.
REQ-006 SHALL have port req_data  input  4*8*ADDER_WIDTH  eight operands per requester; requester r occupies bits [r*8*ADDER_WIDTH +: 8*ADDER_WIDTH], operand k at [k*ADDER_WIDTH +: ADDER_WIDTH] within that slice.
REQ-007 SHALL have port req_ready  output  4  one-hot-or-zero grant; a transfer occurs when req_valid[r] and req_ready[r] are both high at a rising edge.
REQ-008 SHALL have port res_valid  output  1  result-buffer head valid.
REQ-009 SHALL have port res_id  output  2  requester index of head result.
REQ-010 SHALL have port res_sum  output  ADDER_WIDTH+3  unsigned sum of the eight operands of head result.
REQ-011 SHALL have port res_ready  input  1  consumer pop; pop occurs when res_valid and res_ready are both high at a rising edge.

Function
REQ-012 SHALL arbitrate round-robin: search starts at (last_grant+1) mod 4; first requester with req_valid high is granted.
REQ-013 SHALL assert at most one req_ready bit per cycle, combinationally from req_valid, last_grant and credit state.
REQ-014 SHALL keep a credit counter inflight (0..FIFO_DEPTH) counting accepted requests not yet popped; grant only when inflight < FIFO_DEPTH.
REQ-015 SHALL update inflight: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop.
REQ-016 SHALL update last_grant only on an accepting edge.
REQ-017 SHALL compute as a 3-level unsigned binary adder tree: level widths ADDER_WIDTH+1, +2, +3; no truncation, no overflow possible.
REQ-018 SHALL pipeline: stage 1 registers operands and id on the accepting edge E; stage 2 registers the tree sum and id at edge E+1; the result is written to the FIFO at edge E+2.
REQ-019 SHALL present the FIFO head first-word-fall-through; with an empty FIFO, res_valid rises in the cycle after edge E+2 (latency 2 edges after acceptance).
REQ-020 SHALL sustain one accept and one result per cycle while res_ready stays high.
REQ-021 SHALL deliver results in acceptance order; res_sum/res_id SHALL hold stable while res_valid high and res_ready low.
REQ-022 SHALL never overflow the FIFO: credit guarantees a free slot for every in-flight pipeline entry.
REQ-023 SHALL, with inflight == FIFO_DEPTH, drive req_ready = 0 regardless of req_valid; a pop in that cycle frees credit only from the next cycle.

Reset
REQ-024 SHALL, on rst high at a rising edge, clear inflight, FIFO pointers, pipeline valid bits and set last_grant = 3 (requester 0 has first priority).
REQ-025 SHALL drive res_valid = 0, res_id = 0, res_sum = 0 and req_ready = 0 while rst is high and in the first cycle after it is released.
REQ-026 SHALL discard all in-flight and buffered results when rst asserts mid-operation; none SHALL appear after release.

Configuration
REQ-027 SHALL, with macro ADDER_TREE_SCHED_STATS_EN defined, add output grant_cnt (4*16 bits, 16-bit saturating accept counter per requester, slice r at [r*16 +: 16]) and output stall_cnt (16 bits, saturating count of cycles with any req_valid high and inflight == FIFO_DEPTH), all cleared by rst.
REQ-028 SHALL, without ADDER_TREE_SCHED_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-029 Single request: requester 2, operands 1..8, res_ready=1 -> res_valid after edge E+2, res_id=2, res_sum=36.
REQ-030 Maximum values: all operands 15 on requester 0 -> res_sum=120, no truncation.
REQ-031 All four valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; results in same order.
REQ-032 res_ready=0, requester 1 valid continuously -> exactly 4 accepts then req_ready=0; raise res_ready for one edge -> one pop, one further accept next cycle; stall_cnt increments per blocked cycle when STATS_EN defined.
REQ-033 rst asserted with 3 results buffered -> res_valid=0 after release, inflight=0, next grant goes to requester 0.
REQ-034 Saturation (STATS_EN): 70000 accepts on requester 3 -> grant_cnt[3]=65535, other counters 0.
